// File: rtl/jk_cmd_seq_pkg.sv
// Shared definitions for the JK command sequencer: op and state encodings
// plus the JK reference-model step used by the on-line checker.
package jk_cmd_seq_pkg;

    typedef enum logic [1:0] {
        OP_HOLD = 2'b00,
        OP_RST  = 2'b01,
        OP_SET  = 2'b10,
        OP_TGL  = 2'b11
    } jk_op_e;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } seq_state_e;

    // Returns {valid, q} after one edge with the given {j,k} applied.
    function automatic logic [1:0] model_step(input logic [1:0] op,
                                              input logic       q,
                                              input logic       v);
        logic [1:0] r;
        r = {v, q};
        case (jk_op_e'(op))
            OP_RST:  r = 2'b10;
            OP_SET:  r = 2'b11;
            OP_TGL:  r = {v, ~q};
            default: r = {v, q};
        endcase
        return r;
    endfunction

endpackage

// File: rtl/jk_cmd_seq_if.sv
// Command channel into the JK sequencer: valid/ready handshake carrying op and length.
interface jk_cmd_seq_if #(
    parameter int LEN_W = 4
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [LEN_W-1:0] cmd_len;

    modport master (output cmd_valid, cmd_op, cmd_len, input cmd_ready);
    modport slave  (input cmd_valid, cmd_op, cmd_len, output cmd_ready);
endinterface

// File: rtl/jk_cmd_fifo.sv
// Small synchronous FIFO for queued JK commands; wrapping pointers plus an
// explicit occupancy count so full/empty never alias.
module jk_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 6
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   pop,
    output logic [WIDTH-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/jk_cmd_seq.sv
// JK stimulus sequencer: drains queued commands onto registered j/k for len+1
// cycles each and checks the flip-flop's q against a cycle-accurate JK model.
//
// state | meaning
// IDLE  | j/k parked at 00, pops the FIFO head as soon as one is present
// RUN   | holding j/k for the current command, remain counts down to 0
module jk_cmd_seq
    import jk_cmd_seq_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int LEN_W = 4,
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    jk_cmd_seq_if.slave      cmd,
    output logic             j,
    output logic             k,
    input  logic             q_fb,
    output logic             busy,
    output logic             done,
    output logic             exp_q,
    output logic             exp_valid,
    output logic             err,
    output logic [ERR_W-1:0] err_cnt,
    input  logic             clr_err
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int FW    = 2 + LEN_W;

    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic [FW-1:0]    fifo_head;
    logic [1:0]       head_op;
    logic [LEN_W-1:0] head_len;

    seq_state_e       state;
    seq_state_e       state_nxt;
    logic [1:0]       jk_drv;
    logic [1:0]       jk_nxt;
    logic [LEN_W-1:0] remain;
    logic [LEN_W-1:0] remain_nxt;
    logic             mismatch;

    assign cmd.cmd_ready = (fifo_count < CNT_W'(DEPTH));
    assign fifo_push     = cmd.cmd_valid && !fifo_full;

    jk_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (FW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .wdata ({cmd.cmd_op, cmd.cmd_len}),
        .pop   (fifo_pop),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign head_op  = fifo_head[FW-1:LEN_W];
    assign head_len = fifo_head[LEN_W-1:0];

    always_comb begin
        state_nxt  = state;
        jk_nxt     = jk_drv;
        remain_nxt = remain;
        fifo_pop   = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                jk_nxt = OP_HOLD;
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    jk_nxt     = head_op;
                    remain_nxt = head_len;
                    state_nxt  = RUN;
                end
            end
            RUN: begin
                if (remain != '0) begin
                    remain_nxt = remain - LEN_W'(1);
                end else begin
                    done = 1'b1;
                    // Chain straight into the next command so j/k never bubbles.
                    if (!fifo_empty) begin
                        fifo_pop   = 1'b1;
                        jk_nxt     = head_op;
                        remain_nxt = head_len;
                    end else begin
                        jk_nxt    = OP_HOLD;
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            jk_drv <= '0;
            remain <= '0;
        end else begin
            state  <= state_nxt;
            jk_drv <= jk_nxt;
            remain <= remain_nxt;
        end
    end

    assign j    = jk_drv[1];
    assign k    = jk_drv[0];
    assign busy = (state == RUN) || !fifo_empty;

    // The model sees the same registered j/k the flip-flop samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            exp_q     <= 1'b0;
            exp_valid <= 1'b0;
        end else begin
            {exp_valid, exp_q} <= model_step(jk_drv, exp_q, exp_valid);
        end
    end

    assign mismatch = exp_valid && (q_fb != exp_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            err     <= 1'b0;
            err_cnt <= '0;
        end else if (clr_err) begin
            err     <= 1'b0;
            err_cnt <= '0;
        end else if (mismatch) begin
            err <= 1'b1;
            if (err_cnt != '1) begin
                err_cnt <= err_cnt + ERR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_jk_cmd_seq.sv
// Scoreboard bench for jk_cmd_seq with a behavioural jkff on the feedback path.
module tb_jk_cmd_seq;
    import jk_cmd_seq_pkg::*;

    localparam int DEPTH = 4;
    localparam int LEN_W = 4;
    localparam int ERR_W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    jk_cmd_seq_if #(.LEN_W(LEN_W)) cif();

    logic             j, k, q_fb, busy, done, exp_q, exp_valid, err, clr_err;
    logic [ERR_W-1:0] err_cnt;
    logic             q_ff      = 1'b1;
    logic             force_en  = 1'b0;
    logic             force_val = 1'b0;

    assign q_fb = force_en ? force_val : q_ff;

    jk_cmd_seq #(.DEPTH(DEPTH), .LEN_W(LEN_W), .ERR_W(ERR_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd       (cif),
        .j         (j),
        .k         (k),
        .q_fb      (q_fb),
        .busy      (busy),
        .done      (done),
        .exp_q     (exp_q),
        .exp_valid (exp_valid),
        .err       (err),
        .err_cnt   (err_cnt),
        .clr_err   (clr_err)
    );

    // jkff: no reset, q starts at an arbitrary value
    always @(posedge clk) begin
        case ({j, k})
            2'b01:   q_ff <= 1'b0;
            2'b10:   q_ff <= 1'b1;
            2'b11:   q_ff <= ~q_ff;
            default: q_ff <= q_ff;
        endcase
    end

    typedef struct packed {
        logic [1:0] jk;
        logic       q;
        logic       v;
    } exp_t;

    exp_t drv_q[$];
    exp_t done_q[$];
    int   n_vec    = 0;
    int   n_bad    = 0;
    int   cur_run  = 0;
    int   last_run = 0;
    logic m_q      = 1'b0;
    logic m_v      = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Expected per-cycle drive and done records; m_q/m_v hold the model state
    // as seen at the start of each drive cycle.
    task automatic enqueue(input logic [1:0] op, input int len);
        exp_t e;
        for (int i = 0; i <= len; i++) begin
            e.jk = op;
            e.q  = m_q;
            e.v  = m_v;
            if (op != 2'b00) drv_q.push_back(e);
            if (i == len) done_q.push_back(e);
            case (op)
                2'b01:   begin m_q = 1'b0; m_v = 1'b1; end
                2'b10:   begin m_q = 1'b1; m_v = 1'b1; end
                2'b11:   m_q = ~m_q;
                default: ;
            endcase
        end
    endtask

    task automatic push(input logic [1:0] op, input int len, output logic acc);
        @(negedge clk);
        cif.cmd_valid = 1'b1;
        cif.cmd_op    = op;
        cif.cmd_len   = LEN_W'(len);
        acc           = cif.cmd_ready;
        @(posedge clk);
        if (acc) enqueue(op, len);
    endtask

    task automatic drop();
        @(negedge clk);
        cif.cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk(name, busy, 0);
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if ({j, k} != 2'b00) begin
                cur_run++;
                if (drv_q.size() == 0) begin
                    chk("unexpected_drive", {j, k}, 0);
                end else begin
                    e = drv_q.pop_front();
                    chk("drive_jk", {j, k}, e.jk);
                    chk("drive_exp_q", exp_q, e.q);
                    chk("drive_exp_valid", exp_valid, e.v);
                end
            end else begin
                if (cur_run != 0) last_run = cur_run;
                cur_run = 0;
            end
            if (done) begin
                if (done_q.size() == 0) begin
                    chk("unexpected_done", done, 0);
                end else begin
                    e = done_q.pop_front();
                    chk("done_jk", {j, k}, e.jk);
                    chk("done_exp_q", exp_q, e.q);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic acc;
        int   n;
        cif.cmd_valid = 1'b0;
        cif.cmd_op    = 2'b00;
        cif.cmd_len   = '0;
        clr_err       = 1'b0;
        rst           = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_jk", {j, k}, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_exp_q", exp_q, 0);
        chk("rst_exp_valid", exp_valid, 0);
        chk("rst_err", err, 0);
        chk("rst_err_cnt", err_cnt, 0);
        chk("rst_ready", cif.cmd_ready, 1);
        rst = 1'b0;

        // Toggle before any set/reset: q unknown, no checking allowed.
        force_en  = 1'b1;
        force_val = 1'b1;
        push(OP_TGL, 2, acc);
        drop();
        wait_idle("idle_tgl_first");
        force_en = 1'b0;
        chk("tgl_first_exp_valid", exp_valid, 0);
        chk("tgl_first_err", err, 0);
        chk("tgl_first_err_cnt", err_cnt, 0);
        push(OP_SET, 0, acc);
        drop();
        wait_idle("idle_first_set");
        chk("first_set_exp_valid", exp_valid, 1);
        chk("first_set_exp_q", exp_q, 1);
        chk("first_set_err", err, 0);

        // Latency: handshake at E, j/k valid after E+1, three drive cycles.
        push(OP_SET, 2, acc);
        drop();
        chk("latency_idle_jk", {j, k}, 0);
        @(negedge clk);
        chk("latency_first_jk", {j, k}, 2);
        wait_idle("idle_set_len2");
        chk("set_len2_run", last_run, 3);
        chk("set_len2_exp_q", exp_q, 1);
        chk("set_len2_q_fb", q_fb, 1);
        chk("set_len2_err", err, 0);

        push(OP_HOLD, 1, acc);
        drop();
        wait_idle("idle_hold");

        // Back-to-back: 10,11,11,11,11,01 with no gap.
        push(OP_SET, 0, acc);
        push(OP_TGL, 3, acc);
        push(OP_RST, 0, acc);
        drop();
        wait_idle("idle_b2b");
        chk("b2b_run", last_run, 6);
        chk("b2b_exp_q", exp_q, 0);
        chk("b2b_err", err, 0);

        // Fill the FIFO behind a running command; a push while full is dropped.
        push(OP_SET, 15, acc);
        push(OP_TGL, 15, acc);
        push(OP_TGL, 15, acc);
        push(OP_RST, 15, acc);
        push(OP_SET, 15, acc);
        chk("fill_last_accepted", acc, 1);
        push(OP_TGL, 1, acc);
        chk("full_ready", acc, 0);
        @(negedge clk);
        cif.cmd_valid = 1'b0;
        n = 1;
        while (!cif.cmd_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("ready_return_cycle", n, 13);
        wait_idle("idle_fill");
        chk("fill_err", err, 0);

        // Forced mismatch during a set command.
        push(OP_SET, 3, acc);
        drop();
        n = 0;
        while (!(j && !k && exp_valid && exp_q) && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("err_setup_wait", int'(n < 20), 1);
        force_en  = 1'b1;
        force_val = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        force_en = 1'b0;
        chk("mismatch_err", err, 1);
        chk("mismatch_err_cnt", err_cnt, 3);
        force_en = 1'b1;
        clr_err  = 1'b1;
        @(negedge clk);
        force_en = 1'b0;
        clr_err  = 1'b0;
        chk("clr_prio_err", err, 0);
        chk("clr_prio_err_cnt", err_cnt, 0);
        @(negedge clk);
        chk("after_clr_err", err, 0);
        force_en = 1'b1;
        repeat (300) @(negedge clk);
        force_en = 1'b0;
        chk("sat_err_cnt", err_cnt, 255);
        chk("sat_err", err, 1);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        chk("sat_clr_err_cnt", err_cnt, 0);
        wait_idle("idle_err");

        // Reset mid-RUN with two commands queued.
        push(OP_SET, 15, acc);
        push(OP_TGL, 2, acc);
        push(OP_RST, 2, acc);
        drop();
        repeat (3) @(negedge clk);
        chk("pre_rst_busy", busy, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        drv_q.delete();
        done_q.delete();
        m_q = 1'b0;
        m_v = 1'b0;
        @(negedge clk);
        chk("midrst_jk", {j, k}, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_ready", cif.cmd_ready, 1);
        chk("midrst_exp_valid", exp_valid, 0);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_jk", {j, k}, 0);

        chk("drv_q_left", drv_q.size(), 0);
        chk("done_q_left", done_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
